// File: rtl/stp_loader_param.sv
// STP set-polynomial loader: streams N+1 coefficients from data RAM into slot A of S RAM.
// Optional STP_ZERO_FILL_EN zero-fills slot positions N+1..MAX_N after the load.
module stp_loader_param #(
    parameter int BUFFER_SIZE = 1024,
    parameter int COEFF_W     = 16,
    parameter int NUM_SLOTS   = 8,
    parameter int MAX_N       = 10,
    parameter int N_W         = 5,
    localparam int AW  = $clog2(BUFFER_SIZE),
    localparam int A_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_stp,
    input  logic [A_W-1:0]     A,
    input  logic [N_W-1:0]     N,
    input  logic [AW-1:0]      rd_addr_data,
    input  logic [COEFF_W-1:0] rd_data,
    output logic               en_rd_data,
    output logic [AW-1:0]      rd_addr_data_updated,
    output logic               en_wr_S,
    output logic [AW-1:0]      wr_addr_S,
    output logic [COEFF_W-1:0] wr_data_S,
    output logic               en_wr_N,
    output logic [AW-1:0]      wr_addr_N,
    output logic [N_W-1:0]     wr_data_N,
    output logic               done_stp,
    output logic [31:0]        result,
    output logic [31:0]        status
);

    localparam int STRIDE = MAX_N + 1;
    localparam logic [N_W-1:0] NMAX = N_W'(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_DRAIN,
`ifdef STP_ZERO_FILL_EN
        S_FILL,
`endif
        S_ERR,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [A_W-1:0]   a_q;
    logic [N_W-1:0]   n_q;
    logic [AW-1:0]    ptr;
    logic [N_W-1:0]   rk;
    logic [N_W-1:0]   wk;
    logic             wv;
    logic             a_bad;
    logic             n_bad;
    logic             fill_wr;
    logic             fin_ok;
    logic [AW-1:0]    base;

    assign a_bad = int'(a_q) >= NUM_SLOTS;
    assign n_bad = int'(n_q) > MAX_N;
    assign base  = AW'(int'(a_q) * STRIDE);

`ifdef STP_ZERO_FILL_EN
    assign fill_wr = (state == S_FILL);
    assign fin_ok  = (state == S_DRAIN || state == S_FILL)
                     && state_nx == S_DONE;
`else
    assign fill_wr = 1'b0;
    assign fin_ok  = (state == S_DRAIN);
`endif

    // writes lag their reads by one cycle; wk tracks the slot position
    assign en_wr_S   = wv | fill_wr;
    assign wr_addr_S = en_wr_S ? base + AW'(wk) : '0;
    assign wr_data_S = wv ? rd_data : '0;

    assign rd_addr_data_updated = ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            n_q    <= '0;
            ptr    <= '0;
            rk     <= '0;
            wk     <= '0;
            wv     <= 1'b0;
            result <= 32'h0;
            status <= 32'hFFFF_FFFF;
        end else begin
            state <= state_nx;
            wv    <= (state == S_LOAD);
            case (state)
                S_IDLE: begin
                    if (start_stp) begin
                        a_q    <= A;
                        n_q    <= N;
                        ptr    <= rd_addr_data;
                        result <= 32'h0;
                        status <= 32'hFFFF_FFFF;
                    end
                end
                S_CHECK: begin
                    rk <= '0;
                    if (a_bad)
                        status <= 32'd3;
                    else if (n_bad)
                        status <= 32'd2;
                end
                S_LOAD: begin
                    rk  <= rk + 1'b1;
                    wk  <= rk;
                    ptr <= ptr + 1'b1;
                end
                default: begin
                    wk <= wk + 1'b1;
                end
            endcase
            if (fin_ok) begin
                result <= 32'd1;
                status <= 32'd0;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        en_rd_data = 1'b0;
        en_wr_N    = 1'b0;
        wr_addr_N  = '0;
        wr_data_N  = '0;
        done_stp   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_stp)
                    state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (a_bad || n_bad) begin
                    state_nx = S_ERR;
                end else begin
                    en_wr_N   = 1'b1;
                    wr_addr_N = AW'(a_q);
                    wr_data_N = n_q;
                    state_nx  = S_LOAD;
                end
            end
            S_LOAD: begin
                en_rd_data = 1'b1;
                if (rk == n_q)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
`ifdef STP_ZERO_FILL_EN
                if (n_q == NMAX)
                    state_nx = S_DONE;
                else
                    state_nx = S_FILL;
`else
                state_nx = S_DONE;
`endif
            end
`ifdef STP_ZERO_FILL_EN
            S_FILL: begin
                if (wk == NMAX)
                    state_nx = S_DONE;
            end
`endif
            S_ERR: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                done_stp = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule
